// File: rtl/jt900h_busseq_if.sv
// Requester handshakes and external 16-bit bus of the JT900H bus sequencer.
// The sequencer uses the slave modport. A requester/bus model uses the master modport.
`timescale 1ns/1ps
interface jt900h_busseq_if;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic        op_req;
  logic        op_we;
  logic [1:0]  op_size;
  logic [23:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_ack;
  logic [31:0] op_rdata;
  logic        busy;
  logic [23:0] bus_addr;
  logic        bus_cs;
  logic        bus_we;
  logic [1:0]  bus_dsn;
  logic [15:0] bus_dout;
  logic [15:0] bus_din;
  logic        bus_ok;

  modport slave (
    input  fetch_req, fetch_addr, op_req, op_we, op_size, op_addr, op_wdata,
           bus_din, bus_ok,
    output fetch_ack, fetch_data, op_ack, op_rdata, busy,
           bus_addr, bus_cs, bus_we, bus_dsn, bus_dout
  );

  modport master (
    output fetch_req, fetch_addr, op_req, op_we, op_size, op_addr, op_wdata,
           bus_din, bus_ok,
    input  fetch_ack, fetch_data, op_ack, op_rdata, busy,
           bus_addr, bus_cs, bus_we, bus_dsn, bus_dout
  );
endinterface

// File: rtl/jt900h_busseq.sv
// JT900H memory bus sequencer: arbitrates opcode fetch vs operand access on a
// shared 16-bit bus and splits unaligned 8/16/32-bit operands into byte/word cycles.
`timescale 1ns/1ps
module jt900h_busseq (
  input  logic           clk,
  input  logic           rst_n,
  jt900h_busseq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, OPER} state_t;

  // One bus sub-cycle: word-aligned address, active-low lane strobes, lane data.
  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  dsn;
    logic [15:0] dout;
    logic        word;
  } sub_t;

  // Sub-cycle at byte offset 'off' of an access of 'nbytes' bytes starting at 'base'.
  // A word cycle is used whenever the current byte is even and two or more bytes remain.
  function automatic sub_t sub_desc(input logic [23:0] base, input logic [1:0] off,
                                    input logic [2:0] nbytes, input logic [31:0] wdata);
    sub_t       d;
    logic [23:0] ba;
    logic [2:0]  rem;
    logic [7:0]  b0;
    logic [7:0]  b1;
    ba     = base + {22'd0, off};
    rem    = nbytes - {1'b0, off};
    b0     = 8'(wdata >> {off, 3'b000});
    b1     = 8'(wdata >> ({off, 3'b000} + 5'd8));
    d.addr = {ba[23:1], 1'b0};
    d.word = !ba[0] && (rem >= 3'd2);
    if (d.word) begin
      d.dsn  = 2'b00;
      d.dout = {b1, b0};
    end else if (ba[0]) begin
      d.dsn  = 2'b01;
      d.dout = {b0, 8'h00};
    end else begin
      d.dsn  = 2'b10;
      d.dout = {8'h00, b0};
    end
    return d;
  endfunction

  state_t      state_q, state_d;
  logic        last_op_q, last_op_d;      // 1 = operand path was granted last
  logic        we_q, we_d;
  logic [23:0] a_q, a_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [1:0]  last_sub_q, last_sub_d;
  logic [1:0]  sub_q, sub_d;
  logic [1:0]  off_q, off_d;
  logic [23:0] bus_addr_q, bus_addr_d;
  logic        bus_cs_q, bus_cs_d;
  logic        bus_we_q, bus_we_d;
  logic [1:0]  bus_dsn_q, bus_dsn_d;
  logic [15:0] bus_dout_q, bus_dout_d;
  logic        fetch_ack_q, fetch_ack_d;
  logic [15:0] fetch_data_q, fetch_data_d;
  logic        op_ack_q, op_ack_d;
  logic [31:0] op_rdata_q, op_rdata_d;
  logic        busy_q, busy_d;

  logic [2:0]  nb_gnt;
  logic [1:0]  last_gnt;
  sub_t        gnt_sub, cur_sub, nxt_sub;
  logic [1:0]  off_nxt;
  logic [7:0]  lo_byte;
  logic [31:0] rd_merge;

  assign gnt_sub = sub_desc(bus.op_addr, 2'd0, nb_gnt, bus.op_wdata);
  assign cur_sub = sub_desc(a_q, off_q, nbytes_q, wdata_q);
  assign off_nxt = off_q + (cur_sub.word ? 2'd2 : 2'd1);
  assign nxt_sub = sub_desc(a_q, off_nxt, nbytes_q, wdata_q);
  // A lone byte comes from whichever lane its address parity selects.
  assign lo_byte = (cur_sub.dsn == 2'b01) ? bus.bus_din[15:8] : bus.bus_din[7:0];

  // Place the returned lane(s) into the read buffer at the running byte offset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign rd_merge[gi*8 +: 8] =
      (off_q == 2'(gi))                        ? lo_byte :
      (cur_sub.word && (off_q + 2'd1 == 2'(gi))) ? bus.bus_din[15:8] :
                                                  op_rdata_q[gi*8 +: 8];
  end

  // Byte count and index of the final sub-cycle for the operand being granted.
  always_comb begin
    nb_gnt   = 3'd4;
    last_gnt = bus.op_addr[0] ? 2'd2 : 2'd1;
    case (bus.op_size)
      2'd0: begin
        nb_gnt   = 3'd1;
        last_gnt = 2'd0;
      end
      2'd1: begin
        nb_gnt   = 3'd2;
        last_gnt = {1'b0, bus.op_addr[0]};
      end
      default: ;
    endcase
  end

  // Arbitration, sub-cycle sequencing and next values of all bus/result registers.
  always_comb begin
    state_d      = state_q;
    last_op_d    = last_op_q;
    we_d         = we_q;
    a_d          = a_q;
    wdata_d      = wdata_q;
    nbytes_d     = nbytes_q;
    last_sub_d   = last_sub_q;
    sub_d        = sub_q;
    off_d        = off_q;
    bus_addr_d   = bus_addr_q;
    bus_cs_d     = bus_cs_q;
    bus_we_d     = bus_we_q;
    bus_dsn_d    = bus_dsn_q;
    bus_dout_d   = bus_dout_q;
    fetch_ack_d  = 1'b0;
    fetch_data_d = fetch_data_q;
    op_ack_d     = 1'b0;
    op_rdata_d   = op_rdata_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        // No grant in an ack cycle: the requester may still hold req while it sees the ack.
        if (!fetch_ack_q && !op_ack_q) begin
          if (bus.op_req && (!bus.fetch_req || !last_op_q)) begin
            state_d    = OPER;
            last_op_d  = 1'b1;
            we_d       = bus.op_we;
            a_d        = bus.op_addr;
            wdata_d    = bus.op_wdata;
            nbytes_d   = nb_gnt;
            last_sub_d = last_gnt;
            sub_d      = 2'd0;
            off_d      = 2'd0;
            bus_addr_d = gnt_sub.addr;
            bus_cs_d   = 1'b1;
            bus_we_d   = bus.op_we;
            bus_dsn_d  = gnt_sub.dsn;
            bus_dout_d = bus.op_we ? gnt_sub.dout : 16'h0000;
            busy_d     = 1'b1;
            if (!bus.op_we) op_rdata_d = 32'h0;
          end else if (bus.fetch_req) begin
            state_d    = FETCH;
            last_op_d  = 1'b0;
            bus_addr_d = {bus.fetch_addr[23:1], 1'b0};
            bus_cs_d   = 1'b1;
            bus_we_d   = 1'b0;
            bus_dsn_d  = 2'b00;
            bus_dout_d = 16'h0000;
            busy_d     = 1'b1;
          end
        end
      end
      FETCH: begin
        if (bus.bus_ok) begin
          fetch_data_d = bus.bus_din;
          fetch_ack_d  = 1'b1;
          state_d      = IDLE;
          bus_cs_d     = 1'b0;
          bus_we_d     = 1'b0;
          bus_dsn_d    = 2'b11;
          busy_d       = 1'b0;
        end
      end
      OPER: begin
        if (bus.bus_ok) begin
          if (!we_q) op_rdata_d = rd_merge;
          if (sub_q == last_sub_q) begin
            op_ack_d  = 1'b1;
            state_d   = IDLE;
            bus_cs_d  = 1'b0;
            bus_we_d  = 1'b0;
            bus_dsn_d = 2'b11;
            busy_d    = 1'b0;
          end else begin
            sub_d      = sub_q + 2'd1;
            off_d      = off_nxt;
            bus_addr_d = nxt_sub.addr;
            bus_dsn_d  = nxt_sub.dsn;
            bus_dout_d = we_q ? nxt_sub.dout : 16'h0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_op_q    <= 1'b0;
      we_q         <= 1'b0;
      a_q          <= 24'h0;
      wdata_q      <= 32'h0;
      nbytes_q     <= 3'd1;
      last_sub_q   <= 2'd0;
      sub_q        <= 2'd0;
      off_q        <= 2'd0;
      bus_addr_q   <= 24'h0;
      bus_cs_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_dsn_q    <= 2'b11;
      bus_dout_q   <= 16'h0;
      fetch_ack_q  <= 1'b0;
      fetch_data_q <= 16'h0;
      op_ack_q     <= 1'b0;
      op_rdata_q   <= 32'h0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_op_q    <= last_op_d;
      we_q         <= we_d;
      a_q          <= a_d;
      wdata_q      <= wdata_d;
      nbytes_q     <= nbytes_d;
      last_sub_q   <= last_sub_d;
      sub_q        <= sub_d;
      off_q        <= off_d;
      bus_addr_q   <= bus_addr_d;
      bus_cs_q     <= bus_cs_d;
      bus_we_q     <= bus_we_d;
      bus_dsn_q    <= bus_dsn_d;
      bus_dout_q   <= bus_dout_d;
      fetch_ack_q  <= fetch_ack_d;
      fetch_data_q <= fetch_data_d;
      op_ack_q     <= op_ack_d;
      op_rdata_q   <= op_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.fetch_ack  = fetch_ack_q;
  assign bus.fetch_data = fetch_data_q;
  assign bus.op_ack     = op_ack_q;
  assign bus.op_rdata   = op_rdata_q;
  assign bus.busy       = busy_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_cs     = bus_cs_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_dsn    = bus_dsn_q;
  assign bus.bus_dout   = bus_dout_q;

  // Fetch is always word-aligned; the word flag only matters for the current sub-cycle.
  logic unused_bits;
  assign unused_bits = ^{bus.fetch_addr[0], gnt_sub.word, nxt_sub.word};

endmodule

// File: tb/tb_jt900h_busseq.sv
// Bench for jt900h_busseq: directed requests, a byte-memory bus responder, and
// a scoreboard monitor that checks every bus cycle and every ack against queued expectations.
`timescale 1ns/1ps
module tb_jt900h_busseq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  jt900h_busseq_if bif();

  jt900h_busseq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_op;
    logic [31:0] data;
    bit          chk_data;
    int          ack_cyc;
  } ack_t;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  dsn;
    logic        we;
    logic [15:0] dout;
  } cyc_t;

  ack_t ack_q[$];
  cyc_t bus_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stall    = 0;
  logic [7:0] mem [int];
  ack_t ma;
  cyc_t mc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Bus responder: returns memory lanes and inserts 'stall' wait cycles.
  always @(posedge clk) begin
    #1;
    if (bif.bus_cs) begin
      bif.bus_din = {rd(int'(bif.bus_addr) + 1), rd(int'(bif.bus_addr))};
      if (stall > 0) begin
        bif.bus_ok = 1'b0;
        stall--;
      end else begin
        bif.bus_ok = 1'b1;
      end
    end else begin
      bif.bus_ok = (stall == 0);
    end
  end

  // Monitor: pops expected bus cycles and acks as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.bus_cs) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: cycle at %h dsn %b, none expected", bif.bus_addr, bif.bus_dsn);
        end else if (bif.bus_ok) begin
          mc = bus_q.pop_front();
          check("bus_addr", 32'(bif.bus_addr), 32'(mc.addr));
          check("bus_dsn", 32'(bif.bus_dsn), 32'(mc.dsn));
          check("bus_we", 32'(bif.bus_we), 32'(mc.we));
          if (mc.we) check("bus_dout", 32'(bif.bus_dout), 32'(mc.dout));
        end else begin
          mc = bus_q[0];
          check("stall_addr", 32'(bif.bus_addr), 32'(mc.addr));
          check("stall_dsn", 32'(bif.bus_dsn), 32'(mc.dsn));
          check("stall_busy", 32'(bif.busy), 32'd1);
        end
      end
      if (bif.fetch_ack || bif.op_ack) begin
        if (ack_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ack_unexpected: fetch_ack %b op_ack %b, none expected", bif.fetch_ack, bif.op_ack);
        end else begin
          ma = ack_q.pop_front();
          check("ack_kind", {31'd0, bif.op_ack}, {31'd0, ma.is_op});
          if (ma.ack_cyc >= 0) check("ack_cycle", cyc, ma.ack_cyc);
          if (ma.chk_data)
            check(ma.is_op ? "op_rdata" : "fetch_data",
                  ma.is_op ? bif.op_rdata : 32'(bif.fetch_data), ma.data);
        end
      end
    end
  end

  task automatic push_bus(input logic [23:0] a, input logic [1:0] d, input logic w, input logic [15:0] o);
    cyc_t c;
    c.addr = a; c.dsn = d; c.we = w; c.dout = o;
    bus_q.push_back(c);
  endtask

  task automatic push_ack(input bit is_op, input logic [31:0] d, input bit chk, input int at);
    ack_t a;
    a.is_op = is_op; a.data = d; a.chk_data = chk; a.ack_cyc = at;
    ack_q.push_back(a);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acks(input int n, input string nm);
    int got = 0;
    for (int i = 0; i < 60 && got < n; i++) begin
      step();
      if (bif.fetch_ack || bif.op_ack) got++;
    end
    check({nm, "_ack_count"}, got, n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fetch_ack"}, 32'(bif.fetch_ack), 32'd0);
    check({tag, "_op_ack"}, 32'(bif.op_ack), 32'd0);
    check({tag, "_busy"}, 32'(bif.busy), 32'd0);
    check({tag, "_bus_cs"}, 32'(bif.bus_cs), 32'd0);
    check({tag, "_bus_we"}, 32'(bif.bus_we), 32'd0);
    check({tag, "_bus_dsn"}, 32'(bif.bus_dsn), 32'd3);
    check({tag, "_bus_addr"}, 32'(bif.bus_addr), 32'd0);
    check({tag, "_bus_dout"}, 32'(bif.bus_dout), 32'd0);
    check({tag, "_fetch_data"}, 32'(bif.fetch_data), 32'd0);
    check({tag, "_op_rdata"}, bif.op_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    bif.fetch_req = 0; bif.fetch_addr = 0;
    bif.op_req = 0; bif.op_we = 0; bif.op_size = 0; bif.op_addr = 0; bif.op_wdata = 0;
    bif.bus_din = 0; bif.bus_ok = 0;
    mem[32'h001234] = 8'hCD; mem[32'h001235] = 8'hAB;
    mem[32'h000100] = 8'h99; mem[32'h000101] = 8'h11; mem[32'h000102] = 8'h22;
    mem[32'h000103] = 8'h33; mem[32'h000104] = 8'h44; mem[32'h000105] = 8'h77;
    mem[32'h000200] = 8'h5A; mem[32'h000201] = 8'hEE;
    mem[32'h000300] = 8'h01; mem[32'h000301] = 8'h02;
    mem[32'h000400] = 8'h34; mem[32'h000401] = 8'h12;
    mem[32'h000600] = 8'h11; mem[32'h000601] = 8'h9C;

    repeat (3) @(posedge clk);
    #2;
    check_reset("rst");
    rst_n = 1'b1;
    step();

    // Both requests held: op first (reset last_grant = fetch), then alternate, 3-cycle spacing.
    k = cyc;
    push_bus(24'h000200, 2'b10, 1'b0, 16'h0); push_bus(24'h000300, 2'b00, 1'b0, 16'h0);
    push_bus(24'h000200, 2'b10, 1'b0, 16'h0); push_bus(24'h000300, 2'b00, 1'b0, 16'h0);
    push_ack(1, 32'h0000005A, 1, k + 2);
    push_ack(0, 32'h00000201, 1, k + 5);
    push_ack(1, 32'h0000005A, 1, k + 8);
    push_ack(0, 32'h00000201, 1, k + 11);
    bif.op_req = 1; bif.op_we = 0; bif.op_size = 2'd0; bif.op_addr = 24'h000200;
    bif.fetch_req = 1; bif.fetch_addr = 24'h000300;
    wait_acks(4, "alt");
    bif.op_req = 0; bif.fetch_req = 0;
    step();

    // Fetch with odd address: bit 0 ignored.
    k = cyc;
    push_bus(24'h001234, 2'b00, 1'b0, 16'h0);
    push_ack(0, 32'h0000ABCD, 1, k + 2);
    bif.fetch_req = 1; bif.fetch_addr = 24'h001235;
    wait_acks(1, "fetch");
    bif.fetch_req = 0;
    step();

    // Long read at odd address: byte, word, byte.
    k = cyc;
    push_bus(24'h000100, 2'b01, 1'b0, 16'h0);
    push_bus(24'h000102, 2'b00, 1'b0, 16'h0);
    push_bus(24'h000104, 2'b10, 1'b0, 16'h0);
    push_ack(1, 32'h44332211, 1, k + 4);
    bif.op_req = 1; bif.op_we = 0; bif.op_size = 2'd2; bif.op_addr = 24'h000101;
    wait_acks(1, "long_rd");
    bif.op_req = 0;
    step();

    // Word write at 0xFFFFFF wraps to 0; size/data changed after grant must be ignored.
    k = cyc;
    push_bus(24'hFFFFFE, 2'b01, 1'b1, 16'hEF00);
    push_bus(24'h000000, 2'b10, 1'b1, 16'h00BE);
    push_ack(1, 32'h0, 0, k + 3);
    bif.op_req = 1; bif.op_we = 1; bif.op_size = 2'd1; bif.op_addr = 24'hFFFFFF;
    bif.op_wdata = 32'h1234BEEF;
    step();
    bif.op_wdata = 32'h0; bif.op_size = 2'd2;
    wait_acks(1, "wrap_wr");
    bif.op_req = 0;
    step();

    // Word read with 5 wait states.
    k = cyc;
    stall = 5;
    push_bus(24'h000400, 2'b00, 1'b0, 16'h0);
    push_ack(1, 32'h00001234, 1, k + 7);
    bif.op_req = 1; bif.op_we = 0; bif.op_size = 2'd1; bif.op_addr = 24'h000400;
    wait_acks(1, "stall_rd");
    bif.op_req = 0;
    step();

    // Long write interrupted by reset during its second sub-cycle: no ack expected.
    k = cyc;
    push_bus(24'h000500, 2'b00, 1'b1, 16'hC3D4);
    bif.op_req = 1; bif.op_we = 1; bif.op_size = 2'd2; bif.op_addr = 24'h000500;
    bif.op_wdata = 32'hA1B2C3D4;
    step();
    step();
    check("sub2_addr", 32'(bif.bus_addr), 32'h000502);
    check("sub2_dout", 32'(bif.bus_dout), 32'h0000A1B2);
    rst_n = 1'b0;
    bif.op_req = 0;
    #1;
    check_reset("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Byte read at odd address after reset.
    k = cyc;
    push_bus(24'h000600, 2'b01, 1'b0, 16'h0);
    push_ack(1, 32'h0000009C, 1, k + 2);
    bif.op_req = 1; bif.op_we = 0; bif.op_size = 2'd0; bif.op_addr = 24'h000601;
    wait_acks(1, "byte_rd");
    bif.op_req = 0;
    step();
    step();

    check("ack_queue_left", ack_q.size(), 0);
    check("bus_queue_left", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
